// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//
// Serial pattern generator. On a start request it latches a 1..WIDTH-bit
// pattern and sends it MSB-first (pat[len] first), one bit per clock. The
// pattern is repeated rep times, or continuously when rep is 0, until stop.
// A one-cycle done pulse follows the last bit or a stop. All outputs are
// registered.
//
// Parameters
//   WIDTH  maximum pattern length in bits
//   LEN_W  width of len (2**LEN_W >= WIDTH)
//   CNT_W  width of rep and of the internal repeat counter
//
// Ports
//   clk    in   clock, all logic on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   start request, sampled only while idle
//   pat    in   pattern bits, pat[len:0] used
//   len    in   pattern length minus one
//   rep    in   repetition count, 0 = continuous until stop
//   stop   in   terminate after the current bit, honoured while sending
//   x      out  serial data bit, 0 when valid is 0
//   valid  out  x carries a pattern bit
//   frame  out  first bit of each repetition
//   busy   out  stream in progress
//   done   out  one-cycle pulse after the last bit or a stop
// -----------------------------------------------------------------------------
module pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] rep,
  input  logic             stop,
  output logic             x,
  output logic             valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int                PAT_EXT_W = 2 ** LEN_W;
  localparam logic [LEN_W-1:0]  IDX_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg, state_next;
  logic [LEN_W-1:0] idx_reg,   idx_next;
  logic [CNT_W-1:0] rcnt_reg,  rcnt_next;
  logic [WIDTH-1:0] pat_reg,   pat_next;
  logic [LEN_W-1:0] len_reg,   len_next;
  logic [CNT_W-1:0] rep_reg,   rep_next;

  logic x_reg, valid_reg, frame_reg, busy_reg, done_reg;
  logic x_next, valid_next, frame_next, busy_next, done_next;

  // The pattern widened to the full index range of len, so any idx value
  // selects a defined bit; positions at or above WIDTH read as 0.
  logic [PAT_EXT_W-1:0] pat_ext;

  generate
    for (genvar gi = 0; gi < PAT_EXT_W; gi++) begin : g_pat_ext
      if (gi < WIDTH) begin : g_bit
        assign pat_ext[gi] = pat_next[gi];
      end else begin : g_pad
        assign pat_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rcnt_next  = rcnt_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    rep_next   = rep_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          pat_next   = pat;
          len_next   = len;
          rep_next   = rep;
          idx_next   = len;
          rcnt_next  = rep;
        end
      end

      SEND: begin
        if (stop) begin
          state_next = DONE;
        end else if (idx_reg != '0) begin
          idx_next = idx_reg - IDX_ONE;
        end else if (rep_reg == '0 || rcnt_reg > CNT_ONE) begin
          // Wrap to the next repetition; a continuous stream keeps rcnt frozen.
          idx_next = len_reg;
          if (rep_reg != '0) begin
            rcnt_next = rcnt_reg - CNT_ONE;
          end
        end else begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so that they are registered
  // and line up with the cycle the state is in.
  always_comb begin
    busy_next  = (state_next == SEND);
    valid_next = busy_next;
    x_next     = busy_next & pat_ext[idx_next];
    frame_next = busy_next & (idx_next == len_next);
    done_next  = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      rcnt_reg  <= '0;
      pat_reg   <= '0;
      len_reg   <= '0;
      rep_reg   <= '0;
      x_reg     <= 1'b0;
      valid_reg <= 1'b0;
      frame_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      rcnt_reg  <= rcnt_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      rep_reg   <= rep_next;
      x_reg     <= x_next;
      valid_reg <= valid_next;
      frame_reg <= frame_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign x     = x_reg;
  assign valid = valid_reg;
  assign frame = frame_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//
// Self-checking bench for pattern_gen. Each scenario drives a stream, records
// the outputs {x,valid,frame,busy,done} once per cycle, and compares them with
// an expected trace computed from the pattern, length, repeat count and any
// stop/reset cycle using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] pat;
  logic [2:0] len;
  logic [3:0] rep;
  logic       x, valid, frame, busy, done;

  always #5 clk = ~clk;

  pattern_gen #(.WIDTH(8), .LEN_W(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pat   (pat),
    .len   (len),
    .rep   (rep),
    .stop  (stop),
    .x     (x),
    .valid (valid),
    .frame (frame),
    .busy  (busy),
    .done  (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] obs  [0:127];
  logic [4:0] expv [0:127];

  function automatic logic [4:0] outs();
    return {x, valid, frame, busy, done};
  endfunction

  // Expected trace for a stream started at edge E0; cycle c is the c-th cycle
  // after E0. stop_c / rst_c are the cycles at whose end stop / rst is seen
  // (0 = never).
  task automatic build(input logic [7:0] p, input int l, input int r,
                       input int nc, input int stop_c, input int rst_c);
    int total, last, i, pos;
    total = (r == 0) ? (1 << 30) : (l + 1) * r;
    last  = total;
    if (stop_c > 0 && stop_c < last) last = stop_c;
    for (int c = 1; c <= nc; c++) begin
      i   = c - 1;
      pos = i % (l + 1);
      if (rst_c > 0 && c > rst_c)  expv[c] = 5'b00000;
      else if (c <= last)          expv[c] = {p[l - pos], 1'b1, (pos == 0), 1'b1, 1'b0};
      else if (c == last + 1)      expv[c] = 5'b00001;
      else                         expv[c] = 5'b00000;
    end
  endtask

  // Runs nc cycles after the start edge, recording outputs and injecting
  // stop, reset or a second start (with pattern rpat) at the given cycles.
  task automatic run(input int nc, input int stop_c, input int rst_c,
                     input int restart_c, input logic [7:0] rpat);
    for (int c = 1; c <= nc; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
      obs[c] = outs();
      if (c == stop_c) stop = 1'b1;
      if (c == rst_c)  rst  = 1'b1;
      if (c == restart_c) begin
        start = 1'b1;
        pat   = rpat;
        len   = 3'd7;
        rep   = 4'd5;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pat = '0; len = '0; rep = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (outs() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%b expected 00000", outs());
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (outs() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b expected 00000", outs());
    end
    $display("reset: outputs=%b", outs());
  endtask

  task automatic test_basic();
    pat = 8'h05; len = 3'd2; rep = 4'd2; start = 1'b1;
    build(8'h05, 2, 2, 8, 0, 0);
    run(8, 0, 0, 0, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL basic cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("basic: pat=05 len=2 rep=2 cycles=8");
  endtask

  task automatic test_single_bit();
    logic [7:0] pats [2];
    pats[0] = 8'h01;
    pats[1] = 8'hFE;
    for (int k = 0; k < 2; k++) begin
      pat = pats[k]; len = 3'd0; rep = 4'd3; start = 1'b1;
      build(pats[k], 0, 3, 5, 0, 0);
      run(5, 0, 0, 0, 8'h00);
      for (int c = 1; c <= 5; c++) begin
        n_checks++;
        if (obs[c] !== expv[c]) begin
          n_fail++;
          $display("FAIL single_bit pat=%h cycle %0d: outputs=%b expected %b",
                   pats[k], c, obs[c], expv[c]);
        end
      end
      $display("single_bit: pat=%h len=0 rep=3", pats[k]);
    end
  endtask

  task automatic test_continuous_stop();
    pat = 8'hA5; len = 3'd7; rep = 4'd0; start = 1'b1;
    build(8'hA5, 7, 0, 25, 21, 0);
    run(25, 21, 0, 0, 8'h00);
    for (int c = 1; c <= 25; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL continuous_stop cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("continuous_stop: pat=A5 len=7 rep=0 stop at bit 21");
  endtask

  task automatic test_ignore_busy();
    // Second start mid-stream with new pat/len/rep, and start again in DONE.
    pat = 8'h0F; len = 3'd3; rep = 4'd1; start = 1'b1;
    build(8'h0F, 3, 1, 7, 0, 0);
    run(7, 0, 0, 2, 8'hF0);
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL ignore_busy cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("ignore_busy: restart during SEND");
    pat = 8'h0F; len = 3'd3; rep = 4'd1; start = 1'b1;
    build(8'h0F, 3, 1, 8, 0, 0);
    run(8, 0, 0, 5, 8'hF0);
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL ignore_done cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("ignore_busy: start held in DONE");
  endtask

  task automatic test_reset_mid();
    pat = 8'h96; len = 3'd7; rep = 4'd4; start = 1'b1;
    build(8'h96, 7, 4, 6, 0, 3);
    run(6, 0, 3, 0, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("reset_mid: rst at bit 3");
    pat = 8'h3C; len = 3'd7; rep = 4'd4; start = 1'b1;
    build(8'h3C, 7, 4, 35, 0, 0);
    run(35, 0, 0, 0, 8'h00);
    for (int c = 1; c <= 35; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("after_reset: pat=3C len=7 rep=4 cycles=35");
  endtask

  task automatic test_collision();
    pat = 8'hFF; len = 3'd3; rep = 4'd2; start = 1'b1; rst = 1'b1;
    run(3, 0, 0, 0, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (obs[c] !== 5'b00000) begin
        n_fail++;
        $display("FAIL rst_start cycle %0d: outputs=%b expected 00000", c, obs[c]);
      end
    end
    $display("collision: rst with start");
    pat = 8'h0B; len = 3'd3; rep = 4'd2; start = 1'b1;
    build(8'h0B, 3, 2, 5, 2, 2);
    run(5, 2, 2, 0, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (obs[c] !== expv[c]) begin
        n_fail++;
        $display("FAIL rst_stop cycle %0d: outputs=%b expected %b", c, obs[c], expv[c]);
      end
    end
    $display("collision: rst with stop");
  endtask

  task automatic test_random();
    logic [7:0] p;
    int l, r, stop_c, nc;
    for (int k = 0; k < 8; k++) begin
      p = 8'($urandom);
      l = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 4));
      if (r == 0)                       stop_c = int'($urandom_range(1, 20));
      else if ($urandom_range(0, 1) == 1) stop_c = int'($urandom_range(1, (l + 1) * r));
      else                              stop_c = 0;
      nc = ((r == 0) ? stop_c : (l + 1) * r) + 3;
      pat = p; len = 3'(l); rep = 4'(r); start = 1'b1;
      build(p, l, r, nc, stop_c, 0);
      run(nc, stop_c, 0, 0, 8'h00);
      for (int c = 1; c <= nc; c++) begin
        n_checks++;
        if (obs[c] !== expv[c]) begin
          n_fail++;
          $display("FAIL random pat=%h len=%0d rep=%0d stop=%0d cycle %0d: outputs=%b expected %b",
                   p, l, r, stop_c, c, obs[c], expv[c]);
        end
      end
      $display("random: pat=%h len=%0d rep=%0d stop=%0d cycles=%0d", p, l, r, stop_c, nc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_bit();
    test_continuous_stop();
    test_ignore_busy();
    test_reset_mid();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
